ahb_aes_manager: RTL and testbench

AHB-Lite manager that converts simple one-word command requests into single 32-bit AHB transfers toward the AES subordinate, and returns read data and error status to the requester. It sits between the test or control sequencer and the AES AHB subordinate port. It is the initiator end of the same bus, driving exactly the legal traffic the subordinate checks expect. It handles wait states (including the long stall after a write to 0x2c), the two-cycle ERROR response, and a watchdog timeout.

---
 rtl/ahb_aes_manager_if.sv | 37 +++
 rtl/ahb_aes_manager.sv | 157 +++++++++++++++
 tb/tb_ahb_aes_manager.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_aes_manager_if.sv
// Command/response handshake plus AHB-Lite manager bus toward the AES subordinate.
// The master modport is the manager's view; the slave modport is the requester + subordinate view.
interface ahb_aes_manager_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;

  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;

  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] hwdata;
  logic        hready;
  logic [31:0] hrdata;
  logic        hresp;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, hready, hrdata, hresp,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           hsel, haddr, htrans, hwrite, hsize, hburst, hwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, hready, hrdata, hresp,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           hsel, haddr, htrans, hwrite, hsize, hburst, hwdata
  );
endinterface

// File: rtl/ahb_aes_manager.sv
// AHB-Lite manager: turns one-word commands into single 32-bit transfers with a
// wait-state watchdog, reporting read data, ERROR and timeout back to the requester.
//
// state | meaning
// IDLE  | ready for a command, bus idle
// ADDR  | NONSEQ address phase on the bus, waiting for hready
// DATA  | data phase, waiting for hready to complete
module ahb_aes_manager #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input logic              hclk,
  input logic              hrst,
  ahb_aes_manager_if.master bus
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] WDOG_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t      r_state,       w_state_nxt;
  logic [CW-1:0] r_wdog,      w_wdog_nxt;
  logic [31:0] r_wdata,       w_wdata_nxt;
  logic        r_hsel,        w_hsel_nxt;
  logic [31:0] r_haddr,       w_haddr_nxt;
  logic [1:0]  r_htrans,      w_htrans_nxt;
  logic        r_hwrite,      w_hwrite_nxt;
  logic [31:0] r_hwdata,      w_hwdata_nxt;
  logic        r_rsp_valid,   w_rsp_valid_nxt;
  logic [31:0] r_rsp_rdata,   w_rsp_rdata_nxt;
  logic        r_rsp_err,     w_rsp_err_nxt;
  logic        r_rsp_timeout, w_rsp_timeout_nxt;
  logic        w_wdog_expire;

  assign w_wdog_expire = (r_wdog == WDOG_LAST);

  always_ff @(posedge hclk or posedge hrst) begin
    if (hrst) begin
      r_state       <= ST_IDLE;
      r_wdog        <= '0;
      r_wdata       <= '0;
      r_hsel        <= 1'b0;
      r_haddr       <= '0;
      r_htrans      <= HTRANS_IDLE;
      r_hwrite      <= 1'b0;
      r_hwdata      <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_wdog        <= w_wdog_nxt;
      r_wdata       <= w_wdata_nxt;
      r_hsel        <= w_hsel_nxt;
      r_haddr       <= w_haddr_nxt;
      r_htrans      <= w_htrans_nxt;
      r_hwrite      <= w_hwrite_nxt;
      r_hwdata      <= w_hwdata_nxt;
      r_rsp_valid   <= w_rsp_valid_nxt;
      r_rsp_rdata   <= w_rsp_rdata_nxt;
      r_rsp_err     <= w_rsp_err_nxt;
      r_rsp_timeout <= w_rsp_timeout_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_wdog_nxt        = r_wdog;
    w_wdata_nxt       = r_wdata;
    w_hsel_nxt        = r_hsel;
    w_haddr_nxt       = r_haddr;
    w_htrans_nxt      = r_htrans;
    w_hwrite_nxt      = r_hwrite;
    w_hwdata_nxt      = r_hwdata;
    w_rsp_valid_nxt   = 1'b0;
    w_rsp_rdata_nxt   = '0;
    w_rsp_err_nxt     = 1'b0;
    w_rsp_timeout_nxt = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          w_state_nxt  = ST_ADDR;
          w_wdog_nxt   = '0;
          w_haddr_nxt  = bus.cmd_addr;
          w_hwrite_nxt = bus.cmd_write;
          w_hsel_nxt   = 1'b1;
          w_htrans_nxt = HTRANS_NONSEQ;
          w_wdata_nxt  = bus.cmd_wdata;
        end
      end
      ST_ADDR: begin
        if (bus.hready) begin
          w_state_nxt  = ST_DATA;
          w_wdog_nxt   = '0;
          w_htrans_nxt = HTRANS_IDLE;
          w_hsel_nxt   = 1'b0;
          w_hwdata_nxt = r_hwrite ? r_wdata : 32'h0;
        end else if (w_wdog_expire) begin
          w_state_nxt       = ST_IDLE;
          w_wdog_nxt        = '0;
          w_htrans_nxt      = HTRANS_IDLE;
          w_hsel_nxt        = 1'b0;
          w_rsp_valid_nxt   = 1'b1;
          w_rsp_timeout_nxt = 1'b1;
        end else begin
          w_wdog_nxt = r_wdog + CW'(1);
        end
      end
      ST_DATA: begin
        // A first ERROR cycle arrives with hready low and is treated as an ordinary wait.
        if (bus.hready) begin
          w_state_nxt     = ST_IDLE;
          w_wdog_nxt      = '0;
          w_hwdata_nxt    = 32'h0;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_err_nxt   = bus.hresp;
          w_rsp_rdata_nxt = (!r_hwrite && !bus.hresp) ? bus.hrdata : 32'h0;
        end else if (w_wdog_expire) begin
          w_state_nxt       = ST_IDLE;
          w_wdog_nxt        = '0;
          w_htrans_nxt      = HTRANS_IDLE;
          w_hsel_nxt        = 1'b0;
          w_hwdata_nxt      = 32'h0;
          w_rsp_valid_nxt   = 1'b1;
          w_rsp_timeout_nxt = 1'b1;
        end else begin
          w_wdog_nxt = r_wdog + CW'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign bus.cmd_ready   = (r_state == ST_IDLE) & ~hrst;
  assign bus.hsel        = r_hsel;
  assign bus.haddr       = r_haddr;
  assign bus.htrans      = r_htrans;
  assign bus.hwrite      = r_hwrite;
  assign bus.hsize       = 3'b010;
  assign bus.hburst      = 3'b000;
  assign bus.hwdata      = r_hwdata;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_rdata   = r_rsp_rdata;
  assign bus.rsp_err     = r_rsp_err;
  assign bus.rsp_timeout = r_rsp_timeout;

endmodule

// File: tb/tb_ahb_aes_manager.sv
// Bench for ahb_aes_manager: a subordinate model with programmable waits/ERROR, a
// response scoreboard, and a second instance with a short watchdog.
module tb_ahb_aes_manager;

  logic hclk = 1'b0;
  logic hrst = 1'b1;
  always #5 hclk = ~hclk;

  ahb_aes_manager_if bus ();
  ahb_aes_manager_if bus8 ();

  ahb_aes_manager #(.TIMEOUT_CYCLES(256)) dut  (.hclk(hclk), .hrst(hrst), .bus(bus));
  ahb_aes_manager #(.TIMEOUT_CYCLES(8))   dut8 (.hclk(hclk), .hrst(hrst), .bus(bus8));

  int n_err = 0;
  int n_chk = 0;
  int cyc   = 0;
  always @(posedge hclk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        tmo;
    int          cyc;
  } exp_t;
  exp_t sbq[$];
  exp_t mon_e;

  // subordinate model: zero-wait address phase, s_waits low cycles in data phase
  int          s_waits = 0;
  logic        s_err   = 1'b0;
  logic [31:0] s_rd    = 32'h0;
  logic        s_in_data = 1'b0;
  int          s_n = 0;

  always @(negedge hclk) begin
    if (hrst) begin
      s_in_data  = 1'b0;
      bus.hready = 1'b1;
      bus.hresp  = 1'b0;
      bus.hrdata = 32'h0;
    end else if (bus.htrans == 2'b10) begin
      bus.hready = 1'b1;
      bus.hresp  = 1'b0;
      s_in_data  = 1'b1;
      s_n        = 0;
    end else if (s_in_data) begin
      if (s_n < s_waits) begin
        bus.hready = 1'b0;
        bus.hresp  = s_err && (s_n == s_waits - 1);
        s_n++;
      end else begin
        bus.hready = 1'b1;
        bus.hresp  = s_err;
        bus.hrdata = s_rd;
        s_in_data  = 1'b0;
      end
    end else begin
      bus.hready = 1'b1;
      bus.hresp  = 1'b0;
    end
  end

  logic prev_rv = 1'b0;
  always @(negedge hclk) begin
    if (!hrst) begin
      chk("bus_const", {bus.hsize, bus.hburst, bus.htrans[0], prev_rv & bus.rsp_valid,
                        bus.rsp_err & bus.rsp_timeout}, {3'b010, 3'b000, 3'b000});
      if (bus.rsp_valid) begin
        if (sbq.size() == 0) begin
          chk("unexp_rsp", 1, 0);
        end else begin
          mon_e = sbq.pop_front();
          chk("rsp_rdata", bus.rsp_rdata, mon_e.rdata);
          chk("rsp_err", bus.rsp_err, mon_e.err);
          chk("rsp_timeout", bus.rsp_timeout, mon_e.tmo);
          chk("rsp_cycle", cyc, mon_e.cyc);
          chk("rsp_ready", bus.cmd_ready, 1);
        end
      end
    end
    prev_rv = bus.rsp_valid;
  end

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                       input int waits, input logic err, input logic [31:0] rd,
                       input logic push, input logic hold, output int acc);
    int   guard = 0;
    exp_t e;
    while (!bus.cmd_ready && guard < 200) begin
      @(negedge hclk);
      guard++;
    end
    if (guard >= 200) chk("ready_wait", guard, 0);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wd;
    s_waits = waits;
    s_err   = err;
    s_rd    = rd;
    acc = cyc + 1;
    if (push) begin
      e.rdata = (wr || err) ? 32'h0 : rd;
      e.err   = err;
      e.tmo   = 1'b0;
      e.cyc   = acc + 2 + waits;
      sbq.push_back(e);
    end
    @(posedge hclk);
    @(negedge hclk);
    if (!hold) bus.cmd_valid = 1'b0;
    chk("aph_htrans", bus.htrans, 2'b10);
    chk("aph_haddr", bus.haddr, addr);
    chk("aph_hwrite", bus.hwrite, wr);
    chk("aph_hsel", bus.hsel, 1);
    @(posedge hclk);
    @(negedge hclk);
    chk("dph_htrans", bus.htrans, 2'b00);
    chk("dph_hsel", bus.hsel, 0);
    chk("dph_hwdata", bus.hwdata, wr ? wd : 32'h0);
  endtask

  int a0, a1, a2, g;

  initial begin
    bus.cmd_valid  = 1'b0;
    bus.cmd_write  = 1'b0;
    bus.cmd_addr   = 32'h0;
    bus.cmd_wdata  = 32'h0;
    bus8.cmd_valid = 1'b0;
    bus8.cmd_write = 1'b0;
    bus8.cmd_addr  = 32'h0;
    bus8.cmd_wdata = 32'h0;
    bus8.hready    = 1'b1;
    bus8.hresp     = 1'b0;
    bus8.hrdata    = 32'h0;

    #3;
    chk("rst_hsel", bus.hsel, 0);
    chk("rst_htrans", bus.htrans, 0);
    chk("rst_haddr", bus.haddr, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_cmd_ready", bus.cmd_ready, 0);
    chk("rst_const", {bus.hsize, bus.hburst}, 6'b010000);
    @(negedge hclk);
    @(negedge hclk);
    hrst = 1'b0;
    #1;
    chk("post_rst_ready", bus.cmd_ready, 1);

    // zero-wait read of 0x00
    issue(1'b0, 32'h0000_0000, 32'h0, 0, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0, a0);

    // write to 0x2c with a 20-cycle data-phase stall
    issue(1'b1, 32'h0000_002C, 32'h0123_4567, 20, 1'b0, 32'h0, 1'b1, 1'b0, a0);
    for (int i = 0; i < 20; i++) begin
      @(negedge hclk);
      chk("hwdata_hold", bus.hwdata, 32'h0123_4567);
    end

    // ERROR read of 0x40
    issue(1'b0, 32'h0000_0040, 32'h0, 1, 1'b1, 32'h1234_5678, 1'b1, 1'b0, a0);

    // three back-to-back reads with cmd_valid held
    issue(1'b0, 32'h0000_0004, 32'h0, 0, 1'b0, 32'h1111_1111, 1'b1, 1'b1, a0);
    issue(1'b0, 32'h0000_0008, 32'h0, 0, 1'b0, 32'h2222_2222, 1'b1, 1'b1, a1);
    issue(1'b0, 32'h0000_000C, 32'h0, 0, 1'b0, 32'h3333_3333, 1'b1, 1'b0, a2);
    chk("b2b_gap1", a1 - a0, 3);
    chk("b2b_gap2", a2 - a1, 3);

    // watchdog on the 8-cycle instance with hready stuck low in DATA
    @(negedge hclk);
    chk("t8_ready", bus8.cmd_ready, 1);
    bus8.cmd_write = 1'b0;
    bus8.cmd_addr  = 32'h0000_0010;
    bus8.cmd_valid = 1'b1;
    a0 = cyc + 1;
    @(posedge hclk);
    @(negedge hclk);
    bus8.cmd_valid = 1'b0;
    chk("t8_aph", bus8.htrans, 2'b10);
    @(posedge hclk);
    @(negedge hclk);
    bus8.hready = 1'b0;
    g = 0;
    while (!bus8.rsp_valid && g < 30) begin
      @(negedge hclk);
      g++;
    end
    chk("t8_rsp_seen", bus8.rsp_valid, 1);
    chk("t8_cycle", cyc, a0 + 9);
    chk("t8_timeout", bus8.rsp_timeout, 1);
    chk("t8_err", bus8.rsp_err, 0);
    chk("t8_rdata", bus8.rsp_rdata, 0);
    chk("t8_htrans", bus8.htrans, 0);
    chk("t8_hsel", bus8.hsel, 0);
    chk("t8_idle", bus8.cmd_ready, 1);
    bus8.hready = 1'b1;

    // async reset in the middle of a stalled write data phase
    issue(1'b1, 32'h0000_0080, 32'hA5A5_A5A5, 1000, 1'b0, 32'h0, 1'b0, 1'b0, a0);
    repeat (3) @(negedge hclk);
    #2;
    hrst = 1'b1;
    #1;
    chk("arst_hsel", bus.hsel, 0);
    chk("arst_htrans", bus.htrans, 0);
    chk("arst_haddr", bus.haddr, 0);
    chk("arst_hwrite", bus.hwrite, 0);
    chk("arst_hwdata", bus.hwdata, 0);
    chk("arst_rsp_valid", bus.rsp_valid, 0);
    chk("arst_cmd_ready", bus.cmd_ready, 0);
    @(negedge hclk);
    @(negedge hclk);
    hrst = 1'b0;
    #1;
    chk("arst_release_ready", bus.cmd_ready, 1);
    issue(1'b0, 32'h0000_0004, 32'h0, 0, 1'b0, 32'hCAFE_F00D, 1'b1, 1'b0, a0);

    g = 0;
    while (sbq.size() != 0 && g < 100) begin
      @(negedge hclk);
      g++;
    end
    chk("sb_drain", sbq.size(), 0);
    repeat (5) @(negedge hclk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "bench time limit");
  end

endmodule
